// File: rtl/denominator_stream.sv
// Streaming softmax denominator: buffers one N-element vector, tracks the largest
// exponent, then sums every mantissa aligned to that exponent, one element per cycle.
module denominator_stream #(
  parameter int N   = 5,
  parameter int EW  = 5,
  parameter int MW  = 16,
  parameter int GW  = 4,
  parameter int PAD = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EW+MW-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EW+MW+GW+PAD-1:0]    den
);

  localparam int IW = $clog2(N);
  localparam int SW = MW + GW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if ((1 << GW) < N) begin : g_guardCheck
    $error("denominator_stream: 2**GW must be at least N so the sum cannot overflow");
  end

  typedef enum logic [1:0] {
    LOAD,
    ACCUM,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [IW-1:0]    r_idx;
  logic [EW-1:0]    r_maxExp;
  logic [SW-1:0]    r_sum;
  logic             r_outValid;
  logic [EW+MW-1:0] r_buf [N];

  logic             w_accept;
  logic             w_idxLast;
  logic [EW-1:0]    w_inExp;
  logic [EW+MW-1:0] w_elem;
  logic [EW-1:0]    w_elemExp;
  logic [MW-1:0]    w_elemMant;
  logic [EW-1:0]    w_shift;
  logic [31:0]      w_shiftExt;
  logic [SW-1:0]    w_aligned;

  assign w_accept   = in_valid && in_ready;
  assign w_idxLast  = (r_idx == LAST);
  assign w_inExp    = in_data[EW+MW-1:MW];
  assign w_elem     = r_buf[r_idx];
  assign w_elemExp  = w_elem[EW+MW-1:MW];
  assign w_elemMant = w_elem[MW-1:0];

  // max_exp is final once ACCUM starts, so the shift never goes negative
  assign w_shift    = r_maxExp - w_elemExp;
  assign w_shiftExt = 32'(w_shift);
  assign w_aligned  = (w_shiftExt >= 32'(MW)) ? '0 : ({{GW{1'b0}}, w_elemMant} >> w_shift);

  assign in_ready  = (r_state == LOAD);
  assign out_valid = r_outValid;
  assign den       = {r_maxExp, r_sum, {PAD{1'b0}}};

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      LOAD:    if (w_accept && w_idxLast) w_nextState = ACCUM;
      ACCUM:   if (w_idxLast)             w_nextState = DONE;
      DONE:    if (out_ready)             w_nextState = LOAD;
      default:                            w_nextState = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LOAD;
      r_idx      <= '0;
      r_maxExp   <= '0;
      r_sum      <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            if (r_idx == '0 || w_inExp > r_maxExp) r_maxExp <= w_inExp;
            if (w_idxLast) begin
              r_idx <= '0;
              r_sum <= '0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        ACCUM: begin
          r_sum <= r_sum + w_aligned;
          if (w_idxLast) begin
            r_idx      <= '0;
            r_outValid <= 1'b1;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_idx      <= '0;
          end
        end
        default: begin
          r_idx      <= '0;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  // Element storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_idx] <= in_data;
  end

endmodule

// File: tb/tb_denominator_stream.sv
// Directed and randomised checks of denominator_stream against hand-computed
// denominators and a small behavioural reference.
module tb_denominator_stream;

  localparam int N   = 5;
  localparam int EW  = 5;
  localparam int MW  = 16;
  localparam int GW  = 4;
  localparam int PAD = 12;
  localparam int DW  = EW + MW + GW + PAD;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [EW+MW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] den;

  int nChecks = 0;
  int nBad    = 0;

  logic [EW-1:0] vecExp  [N];
  logic [MW-1:0] vecMant [N];

  denominator_stream #(
    .N(N), .EW(EW), .MW(MW), .GW(GW), .PAD(PAD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .den      (den)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkDen(input logic [EW-1:0] e, input logic [MW+GW-1:0] s);
    return {e, s, {PAD{1'b0}}};
  endfunction

  function automatic logic [DW-1:0] refDen();
    logic [EW-1:0]    mx;
    logic [EW-1:0]    d;
    logic [MW+GW-1:0] s;
    int               sh;
    mx = vecExp[0];
    for (int i = 1; i < N; i++) if (vecExp[i] > mx) mx = vecExp[i];
    s = '0;
    for (int i = 0; i < N; i++) begin
      d  = mx - vecExp[i];
      sh = int'(d);
      if (sh < MW) s = s + ({{GW{1'b0}}, vecMant[i]} >> sh);
    end
    return mkDen(mx, s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendElem(input logic [EW-1:0] e, input logic [MW-1:0] m, input int gap);
    logic acc;
    int   k;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = {e, m};
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 100) begin
      acc = in_ready;
      tick();
      k++;
    end
    if (!acc) checkOutput("acceptTimeout", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int maxGap);
    for (int i = 0; i < N; i++)
      sendElem(vecExp[i], vecMant[i], int'($urandom_range(0, maxGap)));
  endtask

  task automatic waitOut(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      tick();
      edges++;
    end
    checkOutput("outValidSeen", 64'(out_valid), 64'(1));
  endtask

  task automatic popOut();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("popValid", 64'(out_valid), 64'(0));
    checkOutput("popReady", 64'(in_ready), 64'(1));
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic fillVec(input logic [EW-1:0] e0, input logic [EW-1:0] e1, input logic [EW-1:0] e2,
                         input logic [EW-1:0] e3, input logic [EW-1:0] e4, input logic [MW-1:0] m);
    vecExp[0] = e0; vecExp[1] = e1; vecExp[2] = e2; vecExp[3] = e3; vecExp[4] = e4;
    for (int i = 0; i < N; i++) vecMant[i] = m;
  endtask

  initial begin
    int       lat;
    int       stall;
    logic     rdy;
    logic [DW-1:0] expDen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rstReady", 64'(in_ready), 64'(1));
    checkOutput("rstValid", 64'(out_valid), 64'(0));
    checkOutput("rstDen", 64'(den), 64'(0));

    $display("[TB] all-equal exponents");
    fillVec(0, 0, 0, 0, 0, 16'h8000);
    applyStimulus(0);
    checkOutput("accumReady", 64'(in_ready), 64'(0));
    waitOut(lat);
    checkOutput("latencyEqual", 64'(lat), 64'(N));
    checkOutput("denEqual", 64'(den), 64'(mkDen(5'd0, 20'h28000)));
    popOut();

    $display("[TB] one smaller exponent, then stall in DONE");
    fillVec(3, 1, 3, 3, 3, 16'h8000);
    applyStimulus(0);
    waitOut(lat);
    checkOutput("latencyMixed", 64'(lat), 64'(N));
    checkOutput("denMixed", 64'(den), 64'(mkDen(5'd3, 20'h22000)));
    in_valid = 1'b1;
    in_data  = {5'd31, 16'hFFFF};
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("holdDen", 64'(den), 64'(mkDen(5'd3, 20'h22000)));
      checkOutput("holdReady", 64'(in_ready), 64'(0));
      checkOutput("holdValid", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("releaseValid", 64'(out_valid), 64'(0));
    checkOutput("releaseReady", 64'(in_ready), 64'(1));

    $display("[TB] largest exponent last, underflowing shifts");
    fillVec(0, 0, 0, 0, 20, 16'hFFFF);
    applyStimulus(0);
    waitOut(lat);
    checkOutput("denLast", 64'(den), 64'(mkDen(5'd20, 20'h0FFFF)));
    popOut();

    $display("[TB] reset mid-LOAD");
    for (int i = 0; i < 3; i++) sendElem(5'd25, 16'hFFFF, 0);
    pulseReset();
    checkOutput("midLoadRstReady", 64'(in_ready), 64'(1));
    fillVec(2, 2, 2, 2, 2, 16'h1000);
    applyStimulus(0);
    waitOut(lat);
    checkOutput("latencyAfterRst", 64'(lat), 64'(N));
    checkOutput("denAfterRst", 64'(den), 64'(mkDen(5'd2, 20'h05000)));
    popOut();

    $display("[TB] reset mid-ACCUM");
    fillVec(9, 9, 9, 9, 9, 16'h4000);
    applyStimulus(0);
    tick();
    tick();
    pulseReset();
    checkOutput("midAccumRstValid", 64'(out_valid), 64'(0));
    checkOutput("midAccumRstReady", 64'(in_ready), 64'(1));
    repeat (8) tick();
    checkOutput("midAccumQuiet", 64'(out_valid), 64'(0));
    checkOutput("midAccumDen", 64'(den), 64'(0));

    $display("[TB] random back-to-back vectors");
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) begin
        vecExp[i]  = EW'($urandom_range(0, 31));
        vecMant[i] = MW'($urandom_range(0, 65535));
      end
      expDen = refDen();
      applyStimulus(2);
      waitOut(lat);
      checkOutput("randDen", 64'(den), 64'(expDen));
      rdy   = 1'b0;
      stall = 0;
      while (!rdy && stall < 50) begin
        rdy       = 1'($urandom_range(0, 1));
        out_ready = rdy;
        tick();
        stall++;
      end
      out_ready = 1'b0;
      checkOutput("randPop", 64'(out_valid), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
